// File: rtl/inv_subbytes_seq.sv
// Inverse SubBytes over a 128-bit AES state, time-multiplexed onto LANES external
// inverse S-box lookups; the state is consumed LANES bytes per beat over BEATS beats.
module inv_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         state_in,
    output logic [8*LANES-1:0]   sbox_in,
    input  logic [8*LANES-1:0]   sbox_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         state_out,
    output logic                 busy
);

    localparam int BEATS  = 16 / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [127:0]        src_q;
    logic [127:0]        res_q;
    logic [127:0]        res_d;
    logic                out_valid_q;
    logic                busy_q;

    // Gated by reset so the upstream never sees a ready while the block is held.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = res_q;

    // Lane j of beat b reads source byte b*LANES+j; decoded from flops only.
    always_comb begin
        sbox_in = '0;
        if (state_q == RUN) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == BEAT_W'(b)) begin
                    for (int j = 0; j < LANES; j++) begin
                        sbox_in[8*LANES-1-8*j -: 8] = src_q[127-8*(b*LANES+j) -: 8];
                    end
                end
            end
        end
    end

    // Byte i of the result lands in beat i/LANES from lane i%LANES.
    always_comb begin
        res_d = res_q;
        for (int i = 0; i < 16; i++) begin
            if (beat_q == BEAT_W'(i / LANES)) begin
                res_d[127-8*i -: 8] = sbox_out[8*LANES-1-8*(i % LANES) -: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            src_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src_q   <= state_in;
                        beat_q  <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    if (beat_q == LAST_BEAT) begin
                        beat_q      <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                DONE: begin
                    // New input waits until the current result has been taken.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: three instances (LANES 4, 1, 16) each wired to a
// reference inverse S-box table, checked against a queued reference model.
module tb_inv_subbytes_seq;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    localparam logic [127:0] KV_IN  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] KV_OUT = 128'h52E3946686EDD30297F962FE27C9997D;

    logic          clk;
    logic          reset;
    logic [2:0]    iv;
    logic [2:0]    ordy;
    logic [127:0]  sin [3];
    logic          ir4, ir1, ir16, ov4, ov1, ov16, bsy4, bsy1, bsy16;
    logic [2:0]    ir, ov, bsy;
    logic [127:0]  sout4, sout1, sout16;
    logic [127:0]  sout [3];
    logic [31:0]   si4, so4;
    logic [7:0]    si1, so1;
    logic [127:0]  si16, so16;
    logic [127:0]  si_any [3];

    logic [127:0]  sb [$];
    int            n_assert;
    int            n_fail;

    assign ir  = {ir16, ir1, ir4};
    assign ov  = {ov16, ov1, ov4};
    assign bsy = {bsy16, bsy1, bsy4};
    assign sout[0] = sout4;
    assign sout[1] = sout1;
    assign sout[2] = sout16;
    assign si_any[0] = {96'b0, si4};
    assign si_any[1] = {120'b0, si1};
    assign si_any[2] = si16;

    for (genvar j = 0; j < 4; j++) begin : g_l4
        assign so4[31-8*j -: 8] = INV_SBOX[11'(2047 - 8*int'(si4[31-8*j -: 8])) -: 8];
    end
    assign so1 = INV_SBOX[11'(2047 - 8*int'(si1)) -: 8];
    for (genvar j = 0; j < 16; j++) begin : g_l16
        assign so16[127-8*j -: 8] = INV_SBOX[11'(2047 - 8*int'(si16[127-8*j -: 8])) -: 8];
    end

    inv_subbytes_seq #(.LANES(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir4), .state_in(sin[0]),
        .sbox_in(si4), .sbox_out(so4), .out_valid(ov4), .out_ready(ordy[0]),
        .state_out(sout4), .busy(bsy4));
    inv_subbytes_seq #(.LANES(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1), .state_in(sin[1]),
        .sbox_in(si1), .sbox_out(so1), .out_valid(ov1), .out_ready(ordy[1]),
        .state_out(sout1), .busy(bsy1));
    inv_subbytes_seq #(.LANES(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir16), .state_in(sin[2]),
        .sbox_in(si16), .sbox_out(so16), .out_valid(ov16), .out_ready(ordy[2]),
        .state_out(sout16), .busy(bsy16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[7'(127-8*i) -: 8] = INV_SBOX[11'(2047 - 8*int'(s[7'(127-8*i) -: 8])) -: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [127:0] d);
        int n;
        sin[k] = d;
        iv[k]  = 1'b1;
        n = 0;
        while (!ir[k] && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", 128'(ir[k]), 128'(1));
        step();
        iv[k] = 1'b0;
        sb.push_back(model(d));
    endtask

    task automatic wait_out(input int k, input int lat, input string tag, output logic [127:0] got);
        int n;
        logic [127:0] exp;
        n = 0;
        while (!ov[k] && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 128'(ov[k]), 128'(1));
        if (lat >= 0) chk({tag, "_latency"}, 128'(n), 128'(lat));
        got = sout[k];
        exp = (sb.size() > 0) ? sb.pop_front() : ~got;
        chk({tag, "_data"}, got, exp);
        chk({tag, "_sbox_done"}, si_any[k], 128'(0));
        ordy[k] = 1'b1;
        step();
        chk({tag, "_valid_drop"}, 128'(ov[k]), 128'(0));
        chk({tag, "_ready_back"}, 128'(ir[k]), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] a, b;
        int seen;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        iv       = '0;
        ordy     = '0;
        for (int k = 0; k < 3; k++) sin[k] = '0;

        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 128'(ir[k]), 128'(0));
            chk("rst_out_valid", 128'(ov[k]), 128'(0));
            chk("rst_busy", 128'(bsy[k]), 128'(0));
            chk("rst_state_out", sout[k], 128'(0));
            chk("rst_sbox_in", si_any[k], 128'(0));
        end
        reset = 1'b0;
        step();
        chk("rel_in_ready", 128'(ir), 128'(3'b111));
        ordy = 3'b111;

        // Known vector, LANES=4, lane-by-lane sequencing
        chk("idle_sbox_in", si_any[0], 128'(0));
        send(0, KV_IN);
        chk("run_c1_sbox", 128'(si4), 128'(32'h00112233));
        chk("run_busy", 128'(bsy[0]), 128'(1));
        chk("run_in_ready", 128'(ir[0]), 128'(0));
        step();
        chk("run_c2_sbox", 128'(si4), 128'(32'h44556677));
        step();
        chk("run_c3_sbox", 128'(si4), 128'(32'h8899AABB));
        step();
        chk("run_c4_sbox", 128'(si4), 128'(32'hCCDDEEFF));
        chk("run_c4_no_valid", 128'(ov[0]), 128'(0));
        step();
        chk("kv4_valid_at_4", 128'(ov[0]), 128'(1));
        wait_out(0, 0, "kv4", got);
        chk("kv4_const", got, KV_OUT);
        chk("idle_sbox_after", si_any[0], 128'(0));

        send(0, {16{8'h63}});
        wait_out(0, 4, "u63", got);
        chk("u63_const", got, 128'(0));
        send(0, {16{8'h7C}});
        wait_out(0, 4, "u7c", got);
        chk("u7c_const", got, {16{8'h01}});
        for (int r = 0; r < 3; r++) begin
            send(0, {$urandom, $urandom, $urandom, $urandom});
            wait_out(0, 4, "rand4", got);
        end

        // Backpressure with a second state waiting upstream
        ordy[0] = 1'b0;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = KV_IN ^ a;
        send(0, a);
        seen = 0;
        while (!ov[0] && seen < 50) begin
            step();
            seen++;
        end
        chk("bp_valid", 128'(ov[0]), 128'(1));
        sin[0] = b;
        iv[0]  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_data", sout[0], model(a));
            chk("bp_in_ready", 128'(ir[0]), 128'(0));
            chk("bp_hold_valid", 128'(ov[0]), 128'(1));
            step();
        end
        got = sout[0];
        chk("bp_first_data", got, sb.pop_front());
        ordy[0] = 1'b1;
        step();
        chk("b2b_valid_drop", 128'(ov[0]), 128'(0));
        chk("b2b_ready", 128'(ir[0]), 128'(1));
        step();
        iv[0] = 1'b0;
        sb.push_back(model(b));
        wait_out(0, 4, "b2b_second", got);

        // Reset on beat 2 of a block
        send(0, KV_IN);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 128'(ir[0]), 128'(0));
        chk("mid_rst_valid", 128'(ov[0]), 128'(0));
        chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
        chk("mid_rst_state_out", sout[0], 128'(0));
        chk("mid_rst_sbox_in", si_any[0], 128'(0));
        step();
        reset = 1'b0;
        sb.delete();
        step();
        chk("mid_rel_in_ready", 128'(ir[0]), 128'(1));
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov[0]) seen++;
            step();
        end
        chk("aborted_no_valid", 128'(seen), 128'(0));
        send(0, {16{8'hFF}});
        wait_out(0, 4, "ff", got);
        chk("ff_const", got, {16{8'h7D}});

        // Same known vector on one lane and on sixteen lanes
        send(1, KV_IN);
        wait_out(1, 16, "kv1", got);
        chk("kv1_const", got, KV_OUT);
        send(2, KV_IN);
        chk("kv16_sbox", si_any[2], KV_IN);
        wait_out(2, 1, "kv16", got);
        chk("kv16_const", got, KV_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
